// File: rtl/matmul_arbiter.sv
// matmul_arbiter: shares one matrix_mul between two requesters.
// Round-robin grant at the multiplier input handshake, an in-order tag FIFO
// of accepted jobs, and result strobes routed back to the issuing requester.
module matmul_arbiter #(
  parameter int DWIDTH = 8,
  parameter int ROW    = 3,
  parameter int COL    = 3,
  parameter int NUM    = 3,
  parameter int DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          req0_valid,
  input  logic                          req1_valid,
  output logic                          req0_ready,
  output logic                          req1_ready,
  input  logic [DWIDTH*ROW*NUM-1:0]     req0_A,
  input  logic [DWIDTH*ROW*NUM-1:0]     req1_A,
  input  logic [DWIDTH*COL*NUM-1:0]     req0_B,
  input  logic [DWIDTH*COL*NUM-1:0]     req1_B,
  output logic                          mm_en,
  output logic                          mm_in_Dvalid,
  input  logic                          mm_out_Dready,
  output logic [DWIDTH*ROW*NUM-1:0]     mm_din_A,
  output logic [DWIDTH*COL*NUM-1:0]     mm_din_B,
  input  logic [2*DWIDTH*ROW*COL-1:0]   mm_dout_C,
  input  logic                          mm_out_vld,
  output logic                          rsp0_vld,
  output logic                          rsp1_vld,
  output logic [2*DWIDTH*ROW*COL-1:0]   rsp_C,
  output logic [$clog2(DEPTH):0]        inflight,
  output logic                          err_underflow
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic {S_OPEN, S_LOCKED} state_t;

  state_t            state, state_nxt;
  logic              gnt;
  logic              last;
  logic              pick;
  logic              grant_ok;
  logic              sel;
  logic              offer;
  logic              accept;
  logic              pop;
  logic              full;
  logic [DEPTH-1:0]  tag_mem;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]   count;

  // Fresh arbitration decision, used only while no offer is locked
  always_comb begin
    full     = (count == FULL_CNT);
    pick     = 1'b0;
    grant_ok = 1'b0;
    if (en && !full) begin
      if (req0_valid && req1_valid) begin
        grant_ok = 1'b1;
        pick     = ~last;
      end else if (req0_valid) begin
        grant_ok = 1'b1;
        pick     = 1'b0;
      end else if (req1_valid) begin
        grant_ok = 1'b1;
        pick     = 1'b1;
      end
    end
  end

  // Offer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OPEN;
    else     state <= state_nxt;
  end

  // Lock a refused offer until the multiplier takes it
  always_comb begin
    state_nxt = state;
    case (state)
      S_OPEN:   if (grant_ok && !mm_out_Dready) state_nxt = S_LOCKED;
      S_LOCKED: if (mm_out_Dready)              state_nxt = S_OPEN;
      default:  state_nxt = S_OPEN;
    endcase
  end

  // Handshake outputs and operand mux; a locked offer ignores en and full
  always_comb begin
    offer        = (state == S_LOCKED) || grant_ok;
    sel          = (state == S_LOCKED) ? gnt : pick;
    accept       = offer & mm_out_Dready;
    mm_in_Dvalid = offer;
    req0_ready   = accept & ~sel;
    req1_ready   = accept & sel;
    mm_din_A     = sel ? req1_A : req0_A;
    mm_din_B     = sel ? req1_B : req0_B;
    mm_en        = en | (count != '0) | (state == S_LOCKED);
    pop          = mm_out_vld & (count != '0);
    inflight     = count;
  end

  // Granted id held across a locked offer; last accepted id for round-robin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt  <= 1'b0;
      last <= 1'b1;
    end else begin
      if (state == S_OPEN && grant_ok) gnt <= pick;
      if (accept) last <= sel;
    end
  end

  // Tag storage; contents are don't-care when not covered by count
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= sel;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered result routing and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_vld      <= 1'b0;
      rsp1_vld      <= 1'b0;
      rsp_C         <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp0_vld <= pop & ~tag_mem[rd_ptr];
      rsp1_vld <= pop & tag_mem[rd_ptr];
      if (pop) rsp_C <= mm_dout_C;
      if (mm_out_vld && count == '0) err_underflow <= 1'b1;
    end
  end

endmodule
